dram_responder: RTL and testbench

Responder end of the core data-RAM request interface. It accepts load/store requests issued by the execution stage, inserts a programmable number of wait states before asserting dram_ready, and performs byte-strobed writes into a local word-addressed array. For accepted reads it returns registered read data to the memory stage one cycle after acceptance. It serves as the data memory for simulation and FPGA builds of the core.

---
 rtl/dram_responder.sv | 115 +++++++++++
 tb/tb_dram_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// dram_responder: responder side of the core data-RAM request interface.
// Inserts WAIT_CYCLES wait states before accepting each request, performs
// byte-strobed stores into a local word array and returns registered load
// data with a one-cycle rvalid pulse.
module dram_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              dram_rvalid
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      count;
  logic [3:0]      count_nxt;
  logic            ready_raw;
  logic            accept;
  logic [AW-1:0]   idx;
  logic            unused_addr;
  logic [XLEN-1:0] mem [DEPTH_WORDS];

  // Byte offset and high address bits are dropped, so out-of-range
  // addresses alias modulo the array depth.
  assign idx         = dram_addr[AW+1:2];
  assign unused_addr = ^{dram_addr[XLEN-1:AW+2], dram_addr[1:0]};

  // Ready is forced low while reset is held so nothing is accepted then.
  assign dram_ready = ready_raw & ~rst;
  assign accept     = dram_req & dram_ready;

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state and ready decode; a dropped request returns to IDLE so the
  // next request waits the full count again.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ready_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dram_req) begin
          if (WAIT_N == 4'd0) begin
            ready_raw = 1'b1;
          end else begin
            count_nxt = 4'd1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!dram_req) begin
          count_nxt = 4'd0;
          state_nxt = ST_IDLE;
        end else if (count == WAIT_N) begin
          ready_raw = 1'b1;
          count_nxt = 4'd0;
          state_nxt = ST_IDLE;
        end else begin
          count_nxt = count + 4'd1;
        end
      end
      default: begin
        count_nxt = 4'd0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte-strobed store into the array; contents are never reset.
  always_ff @(posedge clk) begin
    if (accept && dram_write) begin
      for (int i = 0; i < NB; i++) begin
        if (dram_wstrb[i]) mem[idx][8*i +: 8] <= dram_wdata[8*i +: 8];
      end
    end
  end

  // Registered load data held until the next accepted load; rvalid pulses
  // for the single cycle after a load is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dram_rvalid <= 1'b0;
      dram_rdata  <= '0;
    end else begin
      dram_rvalid <= accept & ~dram_write;
      if (accept && !dram_write) dram_rdata <= mem[idx];
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Testbench for dram_responder: one instance with no wait states and one
// with three, each checked against a word-level memory model.
module tb_dram_responder;

  logic        clk;
  logic        rst;
  logic        req0, wr0, ready0, rvalid0;
  logic [3:0]  strb0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req3, wr3, ready3, rvalid3;
  logic [3:0]  strb3;
  logic [31:0] addr3, wdata3, rdata3;

  int checks;
  int failures;

  logic [31:0] mdl0 [16];
  logic [31:0] mdl3 [16];
  logic [31:0] exp_rd0;
  logic [31:0] exp_rd3;

  dram_responder #(.XLEN(32), .DEPTH_WORDS(4096), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .dram_req(req0), .dram_write(wr0), .dram_wstrb(strb0),
    .dram_addr(addr0), .dram_wdata(wdata0), .dram_ready(ready0),
    .dram_rdata(rdata0), .dram_rvalid(rvalid0));

  dram_responder #(.XLEN(32), .DEPTH_WORDS(4096), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .dram_req(req3), .dram_write(wr3), .dram_wstrb(strb3),
    .dram_addr(addr3), .dram_wdata(wdata3), .dram_ready(ready3),
    .dram_rdata(rdata3), .dram_rvalid(rvalid3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Store result: lanes selected by the strobe take new data, others keep old.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  // One clock cycle on instance 0; called and returns at a falling edge.
  task automatic step0(input logic req, input logic wr, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic rdy, output logic vld, output logic [31:0] rd);
    req0 = req; wr0 = wr; strb0 = s; addr0 = a; wdata0 = d;
    #1 rdy = ready0;
    @(posedge clk);
    #1 vld = rvalid0; rd = rdata0;
    @(negedge clk);
  endtask

  task automatic step3(input logic req, input logic wr, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic rdy, output logic vld, output logic [31:0] rd);
    req3 = req; wr3 = wr; strb3 = s; addr3 = a; wdata3 = d;
    #1 rdy = ready3;
    @(posedge clk);
    #1 vld = rvalid3; rd = rdata3;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; strb0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    req3 = 1'b1; wr3 = 1'b0; strb3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    checks += 6;
    if (ready0 !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", ready0); end
    if (ready3 !== 1'b0) begin failures++; $display("FAIL reset_ready3 got=%b exp=0", ready3); end
    if (rvalid0 !== 1'b0) begin failures++; $display("FAIL reset_rvalid0 got=%b exp=0", rvalid0); end
    if (rvalid3 !== 1'b0) begin failures++; $display("FAIL reset_rvalid3 got=%b exp=0", rvalid3); end
    if (rdata0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    if (rdata3 !== 32'h0) begin failures++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; req3 = 1'b0;
    exp_rd0 = 32'h0; exp_rd3 = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic rdy, vld; logic [31:0] rd;
    step0(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, rdy, vld, rd);
    checks += 2;
    if (rdy !== 1'b1) begin failures++; $display("FAIL basic_store_ready got=%b exp=1", rdy); end
    if (vld !== 1'b0) begin failures++; $display("FAIL basic_store_rvalid got=%b exp=0", vld); end
    step0(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, rdy, vld, rd);
    checks += 3;
    if (rdy !== 1'b1) begin failures++; $display("FAIL basic_load_ready got=%b exp=1", rdy); end
    if (vld !== 1'b1) begin failures++; $display("FAIL basic_load_rvalid got=%b exp=1", vld); end
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_load_data got=%h exp=deadbeef", rd); end
    step0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    checks += 3;
    if (rdy !== 1'b0) begin failures++; $display("FAIL basic_idle_ready got=%b exp=0", rdy); end
    if (vld !== 1'b0) begin failures++; $display("FAIL basic_rvalid_pulse got=%b exp=0", vld); end
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rdata_hold got=%h exp=deadbeef", rd); end
    exp_rd0 = 32'hDEADBEEF;
  endtask

  task automatic test_strobes();
    logic rdy, vld; logic [31:0] rd;
    step0(1'b1, 1'b1, 4'hF, 32'h100, 32'h11223344, rdy, vld, rd);
    step0(1'b1, 1'b1, 4'b0100, 32'h100, 32'hAAAAAAAA, rdy, vld, rd);
    step0(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, rdy, vld, rd);
    checks += 2;
    if (vld !== 1'b1) begin failures++; $display("FAIL strobe_byte_rvalid got=%b exp=1", vld); end
    if (rd !== 32'h11AA3344) begin failures++; $display("FAIL strobe_byte_data got=%h exp=11aa3344", rd); end
    step0(1'b1, 1'b1, 4'b0011, 32'h102, 32'hBBBBBBBB, rdy, vld, rd);
    step0(1'b1, 1'b0, 4'h0, 32'h103, 32'h0, rdy, vld, rd);
    checks += 1;
    if (rd !== 32'h11AABBBB) begin failures++; $display("FAIL strobe_half_data got=%h exp=11aabbbb", rd); end
    step0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    exp_rd0 = 32'h11AABBBB;
  endtask

  task automatic test_alias();
    logic rdy, vld; logic [31:0] rd;
    step0(1'b1, 1'b1, 4'hF, 32'h0000_4000, 32'h5, rdy, vld, rd);
    step0(1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0, rdy, vld, rd);
    checks += 1;
    if (rd !== 32'h5) begin failures++; $display("FAIL alias_data got=%h exp=00000005", rd); end
    step0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    exp_rd0 = 32'h5;
  endtask

  task automatic test_wait3();
    logic rdy, vld; logic [31:0] rd;
    for (int c = 0; c < 4; c++) begin
      step3(1'b1, 1'b1, 4'hF, 32'h100, 32'hCAFEF00D, rdy, vld, rd);
      checks += 2;
      if (rdy !== (c == 3)) begin failures++; $display("FAIL wait3_store_ready c=%0d got=%b exp=%b", c, rdy, c == 3); end
      if (vld !== 1'b0) begin failures++; $display("FAIL wait3_store_rvalid c=%0d got=%b exp=0", c, vld); end
    end
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    for (int c = 0; c < 4; c++) begin
      step3(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, rdy, vld, rd);
      checks += 2;
      if (rdy !== (c == 3)) begin failures++; $display("FAIL wait3_load_ready c=%0d got=%b exp=%b", c, rdy, c == 3); end
      if (vld !== (c == 3)) begin failures++; $display("FAIL wait3_load_rvalid c=%0d got=%b exp=%b", c + 1, vld, c == 3); end
    end
    checks += 1;
    if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL wait3_load_data got=%h exp=cafef00d", rd); end
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    checks += 1;
    if (vld !== 1'b0) begin failures++; $display("FAIL wait3_rvalid_cycle5 got=%b exp=0", vld); end
    exp_rd3 = 32'hCAFEF00D;
  endtask

  task automatic test_flush();
    logic rdy, vld; logic [31:0] rd;
    for (int c = 0; c < 4; c++) step3(1'b1, 1'b1, 4'hF, 32'h104, 32'h0BADC0DE, rdy, vld, rd);
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    // Store requested for two cycles then withdrawn.
    for (int c = 0; c < 2; c++) begin
      step3(1'b1, 1'b1, 4'hF, 32'h104, 32'hFFFFFFFF, rdy, vld, rd);
      checks += 1;
      if (rdy !== 1'b0) begin failures++; $display("FAIL flush_ready c=%0d got=%b exp=0", c, rdy); end
    end
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    checks += 1;
    if (vld !== 1'b0) begin failures++; $display("FAIL flush_rvalid got=%b exp=0", vld); end
    for (int c = 0; c < 4; c++) begin
      step3(1'b1, 1'b0, 4'h0, 32'h104, 32'h0, rdy, vld, rd);
      checks += 1;
      if (rdy !== (c == 3)) begin failures++; $display("FAIL flush_rewait_ready c=%0d got=%b exp=%b", c + 3, rdy, c == 3); end
    end
    checks += 2;
    if (vld !== 1'b1) begin failures++; $display("FAIL flush_load_rvalid got=%b exp=1", vld); end
    if (rd !== 32'h0BADC0DE) begin failures++; $display("FAIL flush_no_write got=%h exp=0badc0de", rd); end
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    exp_rd3 = 32'h0BADC0DE;
  endtask

  function automatic logic [31:0] rand_addr(input int w);
    return ($urandom & 32'hFFFF_C000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random0();
    logic rdy, vld; logic [31:0] rd, a, d; logic wr, req; logic [3:0] s; int w;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      step0(1'b1, 1'b1, 4'hF, rand_addr(i), d, rdy, vld, rd);
      mdl0[i] = d;
    end
    for (int n = 0; n < 120; n++) begin
      req = ($urandom_range(0, 4) != 0);
      wr = $urandom_range(0, 1); s = 4'($urandom); d = $urandom;
      w = $urandom_range(0, 15); a = rand_addr(w);
      step0(req, wr, s, a, d, rdy, vld, rd);
      if (req && wr) mdl0[w] = merge(mdl0[w], d, s);
      if (req && !wr) exp_rd0 = mdl0[w];
      checks += 3;
      if (rdy !== req) begin failures++; $display("FAIL rand0_ready n=%0d got=%b exp=%b", n, rdy, req); end
      if (vld !== (req && !wr)) begin failures++; $display("FAIL rand0_rvalid n=%0d got=%b exp=%b", n, vld, req && !wr); end
      if (rd !== exp_rd0) begin failures++; $display("FAIL rand0_rdata n=%0d got=%h exp=%h", n, rd, exp_rd0); end
    end
    step0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
  endtask

  task automatic test_random3();
    logic rdy, vld; logic [31:0] rd, a, d; logic wr, acc; logic [3:0] s; int w, h;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      for (int c = 0; c < 4; c++) step3(1'b1, 1'b1, 4'hF, rand_addr(i), d, rdy, vld, rd);
      step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
      mdl3[i] = d;
    end
    for (int n = 0; n < 40; n++) begin
      h = $urandom_range(1, 6);
      wr = $urandom_range(0, 1); s = 4'($urandom); d = $urandom;
      w = $urandom_range(0, 15); a = rand_addr(w);
      for (int c = 0; c < h && c < 4; c++) begin
        acc = (c == 3);
        step3(1'b1, wr, s, a, d, rdy, vld, rd);
        if (acc && wr) mdl3[w] = merge(mdl3[w], d, s);
        if (acc && !wr) exp_rd3 = mdl3[w];
        checks += 3;
        if (rdy !== acc) begin failures++; $display("FAIL rand3_ready n=%0d c=%0d got=%b exp=%b", n, c, rdy, acc); end
        if (vld !== (acc && !wr)) begin failures++; $display("FAIL rand3_rvalid n=%0d c=%0d got=%b exp=%b", n, c, vld, acc && !wr); end
        if (rd !== exp_rd3) begin failures++; $display("FAIL rand3_rdata n=%0d got=%h exp=%h", n, rd, exp_rd3); end
      end
      step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
      checks += 1;
      if (vld !== 1'b0) begin failures++; $display("FAIL rand3_idle_rvalid n=%0d got=%b exp=0", n, vld); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic rdy, vld; logic [31:0] rd;
    for (int c = 0; c < 4; c++) step3(1'b1, 1'b1, 4'hF, 32'h200, 32'h12345678, rdy, vld, rd);
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    for (int c = 0; c < 4; c++) step3(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, rdy, vld, rd);
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    for (int c = 0; c < 2; c++) step3(1'b1, 1'b1, 4'hF, 32'h200, 32'hFFFFFFFF, rdy, vld, rd);
    req3 = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (ready3 !== 1'b0) begin failures++; $display("FAIL rstwait_ready got=%b exp=0", ready3); end
    if (rvalid3 !== 1'b0) begin failures++; $display("FAIL rstwait_rvalid got=%b exp=0", rvalid3); end
    if (rdata3 !== 32'h0) begin failures++; $display("FAIL rstwait_rdata got=%h exp=0", rdata3); end
    if (rdata0 !== 32'h0) begin failures++; $display("FAIL rstwait_rdata0 got=%h exp=0", rdata0); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; req3 = 1'b0;
    exp_rd0 = 32'h0; exp_rd3 = 32'h0;
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
    for (int c = 0; c < 4; c++) begin
      step3(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, rdy, vld, rd);
      checks += 1;
      if (rdy !== (c == 3)) begin failures++; $display("FAIL rstwait_after_ready c=%0d got=%b exp=%b", c, rdy, c == 3); end
    end
    checks += 1;
    if (rd !== 32'h12345678) begin failures++; $display("FAIL rstwait_word_kept got=%h exp=12345678", rd); end
    step3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, rdy, vld, rd);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_strobes();
    test_alias();
    test_wait3();
    test_flush();
    test_random0();
    test_random3();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
